div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 22 ++
 rtl/div_unit.sv | 179 +++++++++++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the iterative HI/LO divider used by DIV/DIVU in EX.
// The constants mirror the pipeline's global defines: register bus width, zero
// word, HI/LO write-enable level, reset level and divider state encodings.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int              RegBus    = 32;
    localparam logic [31:0]     ZEROWORD  = 32'h0000_0000;
    localparam logic            WRITEABLE = 1'b1;
    localparam logic            RESETABLE = 1'b1;

    // Divider FSM encodings (2 bits, legacy-compatible constants)
    localparam logic [1:0]      DivIdle   = 2'b00;
    localparam logic [1:0]      DivBusy   = 2'b01;
    localparam logic [1:0]      DivDone   = 2'b10;

    localparam logic            DivStart  = 1'b1;
    localparam logic            DivStop   = 1'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Radix-2 restoring divider, one quotient bit per clock. Operands are captured
// as magnitudes in IDLE, DATA_W iterations run in BUSY, and the sign-corrected
// results are registered on the edge entering DONE together with a one-cycle
// HI/LO write pulse.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start_i    division request, sampled only in IDLE
//   signed_i   1 = DIV (two's complement), 0 = DIVU
//   dividend_i rs operand
//   divisor_i  rt operand
//   annul_i    abort the division in flight (flush / exception)
//   busy_o     pipeline stall request (BUSY and DONE)
//   we_o       HI/LO write enable, one-cycle pulse in DONE
//   hi_o       remainder
//   lo_o       quotient
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              annul_i,
    output logic              busy_o,
    output logic              we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              qsign_q, qsign_d;
    logic              rsign_q, rsign_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;

    logic [DATA_W:0]   r_shift;
    logic [DATA_W-1:0] r_sub;
    logic              q_bit;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;

    // Two's complement negate when en is set; -2^(DATA_W-1) maps to itself,
    // which as an unsigned magnitude is exactly right.
    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x,
                                                 input logic              en);
        return en ? -x : x;
    endfunction

    // The partial remainder stays below the divisor, so DATA_W bits hold it;
    // only the shifted trial value needs the extra top bit for the compare.
    always_comb begin
        r_shift = {rem_q, dvd_q[DATA_W-1]};
        r_sub   = r_shift[DATA_W-1:0] - dvs_q;
        q_bit   = (r_shift >= {1'b0, dvs_q});
        rem_nxt = q_bit ? r_sub : r_shift[DATA_W-1:0];
        quo_nxt = {quo_q[DATA_W-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        busy_d  = busy_q;
        we_d    = ~WRITEABLE;

        case (state_q)
            DivIdle: begin
                if (start_i == DivStart && !annul_i) begin
                    dvd_d   = neg_if(dividend_i, signed_i & dividend_i[DATA_W-1]);
                    dvs_d   = neg_if(divisor_i,  signed_i & divisor_i[DATA_W-1]);
                    qsign_d = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                    rsign_d = signed_i & dividend_i[DATA_W-1];
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    if (divisor_i == '0) begin
                        // Divide by zero: deterministic zero result, still written
                        state_d = DivDone;
                        we_d    = WRITEABLE;
                        hi_d    = '0;
                        lo_d    = '0;
                    end else begin
                        state_d = DivBusy;
                    end
                end
            end
            DivBusy: begin
                if (annul_i) begin
                    state_d = DivIdle;
                    busy_d  = 1'b0;
                end else begin
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = DivDone;
                        we_d    = WRITEABLE;
                        lo_d    = neg_if(quo_nxt, qsign_q);
                        hi_d    = neg_if(rem_nxt, rsign_q);
                    end
                end
            end
            DivDone: begin
                // Annulled or not, DONE always returns to IDLE; the write
                // pulse has already been presented for its single cycle.
                state_d = DivIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = DivIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RESETABLE) begin
            state_q <= DivIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= DivStop;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
        end
    end

    assign busy_o = busy_q;
    assign we_o   = we_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: directed cases, randomized divisions against
// an arithmetic reference model, annul, and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic        busy_o;
    logic        we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .busy_o     (busy_o),
        .we_o       (we_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    // Reference: plain integer division; signed truncates toward zero and the
    // remainder takes the dividend's sign. Divide by zero yields zeros.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic s, input bit noise, input string name);
        logic [31:0] eq, er, gh, gl;
        int n, bc, wc, wn, lat;
        ref_div(a, b, s, eq, er);
        lat = (b == 32'd0) ? 1 : 33;
        n = 0; bc = 0; wc = 0; wn = -1; gh = 'x; gl = 'x;
        @(negedge clk);
        dividend_i = a; divisor_i = b; signed_i = s; start_i = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (busy_o) bc++;
            if (we_o) begin
                wc++; wn = n; gh = hi_o; gl = lo_o;
            end
            if (noise && n >= 3 && n <= 20) begin
                start_i    = 1'($urandom_range(0, 1));
                dividend_i = $urandom;
                divisor_i  = $urandom;
                signed_i   = 1'($urandom_range(0, 1));
            end else begin
                start_i = 1'b0;
            end
            if (!busy_o) break;
        end
        start_i = 1'b0;
        checks++;
        if (wc !== 1) begin
            errors++; $display("FAIL %s we_count got %0d want 1", name, wc);
        end
        checks++;
        if (wn !== lat) begin
            errors++; $display("FAIL %s we_latency got %0d want %0d", name, wn, lat);
        end
        checks++;
        if (gl !== eq) begin
            errors++; $display("FAIL %s lo got %h want %h", name, gl, eq);
        end
        checks++;
        if (gh !== er) begin
            errors++; $display("FAIL %s hi got %h want %h", name, gh, er);
        end
        checks++;
        if (bc !== lat) begin
            errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, bc, lat);
        end
        @(negedge clk);
        checks++;
        if (hi_o !== er || lo_o !== eq) begin
            errors++;
            $display("FAIL %s hold hi/lo got %h/%h want %h/%h", name, hi_o, lo_o, er, eq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || we_o !== 1'b0) begin
            errors++; $display("FAIL reset busy/we got %b/%b want 0/0", busy_o, we_o);
        end
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++; $display("FAIL reset hi/lo got %h/%h want 0/0", hi_o, lo_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || we_o !== 1'b0) begin
            errors++; $display("FAIL idle busy/we got %b/%b want 0/0", busy_o, we_o);
        end
    endtask

    task automatic test_directed();
        run_div(32'd7,          32'd2,          1'b0, 1'b0, "divu_7_2");
        run_div(32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, "div_m7_2");
        run_div(32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0, "divu_fff9_2");
        run_div(32'd5,          32'd0,          1'b1, 1'b0, "div_by_zero");
        run_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, "div_overflow");
        run_div(32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, "divu_max_1");
        run_div(32'd3,          32'hFFFF_FFFD,  1'b1, 1'b0, "div_3_m3");
        run_div(32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, "divu_1_max");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (k % 8 == 7) b = 32'd0;
            s = 1'($urandom_range(0, 1));
            run_div(a, b, s, (b != 32'd0) && (k % 2 == 0), "random");
        end
    endtask

    task automatic test_annul();
        logic [31:0] ph, pl;
        int wc;
        ph = hi_o; pl = lo_o; wc = 0;
        @(negedge clk);
        dividend_i = 32'd1000; divisor_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (we_o) wc++;
            start_i = 1'b0;
        end
        annul_i = 1'b1; start_i = 1'b1; dividend_i = 32'd55; divisor_i = 32'd5;
        @(negedge clk);
        if (we_o) wc++;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL annul busy got %b want 0", busy_o);
        end
        annul_i = 1'b0; start_i = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (we_o) wc++;
        end
        checks++;
        if (wc !== 0) begin
            errors++; $display("FAIL annul we_pulses got %0d want 0", wc);
        end
        checks++;
        if (hi_o !== ph || lo_o !== pl) begin
            errors++; $display("FAIL annul hold hi/lo got %h/%h want %h/%h", hi_o, lo_o, ph, pl);
        end
        run_div(32'd100, 32'd7, 1'b0, 1'b0, "after_annul_100_7");
    endtask

    task automatic test_async_reset();
        int wc, bc;
        wc = 0; bc = 0;
        @(negedge clk);
        dividend_i = 32'd12345; divisor_i = 32'd17; signed_i = 1'b1; start_i = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n >= 3 && n <= 6) begin
                start_i = 1'b1; dividend_i = $urandom; divisor_i = 32'd0;
            end else begin
                start_i = 1'b0;
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || we_o !== 1'b0) begin
            errors++; $display("FAIL async_rst busy/we got %b/%b want 0/0", busy_o, we_o);
        end
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++; $display("FAIL async_rst hi/lo got %h/%h want 0/0", hi_o, lo_o);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (we_o) wc++;
            if (busy_o) bc++;
        end
        checks++;
        if (wc !== 0 || bc !== 0) begin
            errors++; $display("FAIL async_rst after we/busy cycles got %0d/%0d want 0/0", wc, bc);
        end
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, "after_reset_m100_7");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_unit
